// File: rtl/w_writeback.sv
// ---------------------------------------------------------------------------
// w_writeback -- write-back stage of the five-stage pipelined MIPS core.
//
// Holds the M/W pipeline register, selects the value written to the GRF
// (ALU result, extracted load data, PC+8 or HI/LO) and counts retired
// instructions. Its outputs drive the GRF write port and the W-stage
// forwarding source.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk          core clock, rising-edge active
//   reset        asynchronous, active-low; 0 clears all state immediately
//   stall_W      hold every W-stage register
//   flush_W      load a bubble instead of the M-stage values
//   RFWr_M       M-stage instruction writes the GRF
//   RegWrite_M   M-stage destination register
//   ResultSel_M  result source: 00 ALU, 01 DM, 10 PC+8, 11 HI/LO
//   LoadType_M   000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu (others act as lw)
//   PC4_M        PC+4 of the M-stage instruction
//   ALUOut_M     ALU result; bits [1:0] double as the load byte offset
//   DMRD_M       raw data-memory word
//   HiLo_M       HI/LO read value
//   RFWr_W       GRF write enable (never asserted for $0)
//   RegWrite_W   GRF write address
//   Result_W     GRF write data
//   PC4_W        PC+4 of the W-stage instruction
//   Retired_W    count of committed instructions
//
// Optional feature:
//   WB_TRACE_EN  when defined, prints the simulation commit trace on every
//                edge that writes the GRF while out of reset.
// ---------------------------------------------------------------------------
module w_writeback #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_W,
    input  logic             flush_W,
    input  logic             RFWr_M,
    input  logic [4:0]       RegWrite_M,
    input  logic [1:0]       ResultSel_M,
    input  logic [2:0]       LoadType_M,
    input  logic [31:0]      PC4_M,
    input  logic [31:0]      ALUOut_M,
    input  logic [31:0]      DMRD_M,
    input  logic [31:0]      HiLo_M,
    output logic             RFWr_W,
    output logic [4:0]       RegWrite_W,
    output logic [31:0]      Result_W,
    output logic [31:0]      PC4_W,
    output logic [CNT_W-1:0] Retired_W
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_DM   = 2'b01,
        SEL_PC8  = 2'b10,
        SEL_HILO = 2'b11
    } result_sel_t;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } load_type_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             rfwr_q;
    logic [4:0]       reg_write_q;
    logic [1:0]       result_sel_q;
    logic [2:0]       load_type_q;
    logic [31:0]      pc4_q;
    logic [31:0]      alu_out_q;
    logic [31:0]      dmrd_q;
    logic [31:0]      hilo_q;
    logic [CNT_W-1:0] retired_q;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_val;

    // A nonzero PC4 marks a real instruction; bubbles carry PC4 == 0. The
    // instruction currently in W retires on any edge that lets it leave,
    // which includes an edge that replaces it with a flush bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rfwr_q       <= 1'b0;
            reg_write_q  <= 5'd0;
            result_sel_q <= 2'b00;
            load_type_q  <= 3'b000;
            pc4_q        <= 32'd0;
            alu_out_q    <= 32'd0;
            dmrd_q       <= 32'd0;
            hilo_q       <= 32'd0;
            retired_q    <= '0;
        end else if (!stall_W) begin
            if (pc4_q != 32'd0) begin
                retired_q <= retired_q + CNT_ONE;
            end
            if (flush_W) begin
                rfwr_q       <= 1'b0;
                reg_write_q  <= 5'd0;
                result_sel_q <= 2'b00;
                load_type_q  <= 3'b000;
                pc4_q        <= 32'd0;
                alu_out_q    <= 32'd0;
                dmrd_q       <= 32'd0;
                hilo_q       <= 32'd0;
            end else begin
                rfwr_q       <= RFWr_M;
                reg_write_q  <= RegWrite_M;
                result_sel_q <= ResultSel_M;
                load_type_q  <= LoadType_M;
                pc4_q        <= PC4_M;
                alu_out_q    <= ALUOut_M;
                dmrd_q       <= DMRD_M;
                hilo_q       <= HiLo_M;
            end
        end
    end

    // Little-endian extraction: byte lane from ALUOut[1:0], half lane from
    // ALUOut[1] alone (ALUOut[0] is ignored for halfword loads).
    always_comb begin
        ld_byte = dmrd_q[7:0];
        case (alu_out_q[1:0])
            2'd0:    ld_byte = dmrd_q[7:0];
            2'd1:    ld_byte = dmrd_q[15:8];
            2'd2:    ld_byte = dmrd_q[23:16];
            default: ld_byte = dmrd_q[31:24];
        endcase
        ld_half = alu_out_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];

        load_val = dmrd_q;
        case (load_type_q)
            LD_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   load_val = {24'd0, ld_byte};
            LD_H:    load_val = {{16{ld_half[15]}}, ld_half};
            LD_HU:   load_val = {16'd0, ld_half};
            default: load_val = dmrd_q;
        endcase
    end

    always_comb begin
        Result_W = alu_out_q;
        case (result_sel_q)
            SEL_ALU:  Result_W = alu_out_q;
            SEL_DM:   Result_W = load_val;
            SEL_PC8:  Result_W = pc4_q + 32'd4;
            SEL_HILO: Result_W = hilo_q;
            default:  Result_W = alu_out_q;
        endcase
    end

    // $0 is hard-wired to zero, so a write to it is never signalled.
    assign RFWr_W     = rfwr_q && (reg_write_q != 5'd0);
    assign RegWrite_W = reg_write_q;
    assign PC4_W      = pc4_q;
    assign Retired_W  = retired_q;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && RFWr_W) begin
            $display("%d@%h: $%d <= %h", $time, PC4_W - 32'd4, RegWrite_W, Result_W);
        end
    end
`endif

endmodule

// File: tb/tb_w_writeback.sv
// ---------------------------------------------------------------------------
// tb_w_writeback -- self-checking bench for w_writeback.
//
// Drives directed and random M-stage traffic into two instances (default
// counter width and a 4-bit counter) and compares every output against a
// behavioural model of the write-back stage kept in this file.
// ---------------------------------------------------------------------------
module tb_w_writeback;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        rfwr_m;
    logic [4:0]  rd_m;
    logic [1:0]  sel_m;
    logic [2:0]  lt_m;
    logic [31:0] pc4_m;
    logic [31:0] alu_m;
    logic [31:0] dmrd_m;
    logic [31:0] hilo_m;

    logic        rfwr_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [31:0] pc4_w;
    logic [31:0] ret_w;

    logic        rfwr_w4;
    logic [4:0]  rd_w4;
    logic [31:0] result_w4;
    logic [31:0] pc4_w4;
    logic [3:0]  ret_w4;

    int total = 0;
    int bad   = 0;

    // Model state: the instruction currently sitting in W.
    bit          m_rfwr;
    int unsigned m_rd;
    int unsigned m_sel;
    int unsigned m_lt;
    int unsigned m_pc4;
    int unsigned m_alu;
    int unsigned m_dmrd;
    int unsigned m_hilo;
    int unsigned m_ret;

    w_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .stall_W    (stall),
        .flush_W    (flush),
        .RFWr_M     (rfwr_m),
        .RegWrite_M (rd_m),
        .ResultSel_M(sel_m),
        .LoadType_M (lt_m),
        .PC4_M      (pc4_m),
        .ALUOut_M   (alu_m),
        .DMRD_M     (dmrd_m),
        .HiLo_M     (hilo_m),
        .RFWr_W     (rfwr_w),
        .RegWrite_W (rd_w),
        .Result_W   (result_w),
        .PC4_W      (pc4_w),
        .Retired_W  (ret_w)
    );

    w_writeback #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .stall_W    (stall),
        .flush_W    (flush),
        .RFWr_M     (rfwr_m),
        .RegWrite_M (rd_m),
        .ResultSel_M(sel_m),
        .LoadType_M (lt_m),
        .PC4_M      (pc4_m),
        .ALUOut_M   (alu_m),
        .DMRD_M     (dmrd_m),
        .HiLo_M     (hilo_m),
        .RFWr_W     (rfwr_w4),
        .RegWrite_W (rd_w4),
        .Result_W   (result_w4),
        .PC4_W      (pc4_w4),
        .Retired_W  (ret_w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Value the GRF should receive, derived from the architectural rules.
    function automatic int unsigned modelResult();
        int unsigned k;
        int unsigned b;
        int unsigned h;
        k = m_alu % 4;
        b = (m_dmrd / (1 << (8 * k))) % 256;
        h = (m_dmrd / (1 << (16 * (k / 2)))) % 65536;
        case (m_sel)
            0: return m_alu;
            2: return m_pc4 + 4;
            3: return m_hilo;
            default: begin
                case (m_lt)
                    1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
                    2: return b;
                    3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
                    4: return h;
                    default: return m_dmrd;
                endcase
            end
        endcase
    endfunction

    task automatic modelReset();
        m_rfwr = 0; m_rd = 0; m_sel = 0; m_lt = 0;
        m_pc4 = 0; m_alu = 0; m_dmrd = 0; m_hilo = 0; m_ret = 0;
    endtask

    task automatic checkAll();
        checkOutput("rfwr", {31'd0, rfwr_w}, {31'd0, m_rfwr && (m_rd != 0)});
        checkOutput("regwrite", {27'd0, rd_w}, m_rd);
        checkOutput("result", result_w, modelResult());
        checkOutput("pc4", pc4_w, m_pc4);
        checkOutput("retired", ret_w, m_ret);
        checkOutput("retired4", {28'd0, ret_w4}, m_ret % 16);
    endtask

    task automatic applyStimulus(input bit st, input bit fl, input bit rf,
                                 input logic [4:0] rd, input logic [1:0] sel,
                                 input logic [2:0] lt, input logic [31:0] pc4,
                                 input logic [31:0] alu, input logic [31:0] dmrd,
                                 input logic [31:0] hilo);
        stall = st; flush = fl; rfwr_m = rf; rd_m = rd; sel_m = sel;
        lt_m = lt; pc4_m = pc4; alu_m = alu; dmrd_m = dmrd; hilo_m = hilo;
        @(posedge clk);
        if (!st) begin
            if (m_pc4 != 0) m_ret = m_ret + 1;
            if (fl) begin
                m_rfwr = 0; m_rd = 0; m_sel = 0; m_lt = 0;
                m_pc4 = 0; m_alu = 0; m_dmrd = 0; m_hilo = 0;
            end else begin
                m_rfwr = rf; m_rd = rd; m_sel = sel; m_lt = lt;
                m_pc4 = pc4; m_alu = alu; m_dmrd = dmrd; m_hilo = hilo;
            end
        end
        #1;
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic asyncReset();
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_rfwr", {31'd0, rfwr_w}, 32'd0);
        checkOutput("rst_pc4", pc4_w, 32'd0);
        checkOutput("rst_result", result_w, 32'd0);
        checkAll();
        #2;
        reset = 1'b1;
    endtask

    logic [31:0] held_pc4;
    logic [31:0] held_ret;

    initial begin
        reset = 1'b0;
        stall = 0; flush = 0; rfwr_m = 0; rd_m = 0; sel_m = 0; lt_m = 0;
        pc4_m = 0; alu_m = 0; dmrd_m = 0; hilo_m = 0;
        modelReset();
        #12;
        reset = 1'b1;

        // Pending write, then reset mid-cycle.
        applyStimulus(0, 0, 1, 5'd9, 2'd0, 3'd0, 32'h3000, 32'hDEAD, 32'd0, 32'd0);
        asyncReset();
        for (int i = 0; i < 3; i++) idle();
        checkOutput("ret_after_reset", ret_w, 32'd0);

        // ALU writeback.
        applyStimulus(0, 0, 1, 5'd8, 2'd0, 3'd0, 32'h3004, 32'h1234, 32'd0, 32'd0);
        checkOutput("alu_rfwr", {31'd0, rfwr_w}, 32'd1);
        checkOutput("alu_rd", {27'd0, rd_w}, 32'd8);
        checkOutput("alu_result", result_w, 32'h1234);

        // Loads from 0x80FF7F01.
        applyStimulus(0, 0, 1, 5'd2, 2'd1, 3'd1, 32'h3008, 32'h1003, 32'h80FF7F01, 32'd0);
        checkOutput("lb_k3", result_w, 32'hFFFFFF80);
        applyStimulus(0, 0, 1, 5'd3, 2'd1, 3'd2, 32'h300C, 32'h1002, 32'h80FF7F01, 32'd0);
        checkOutput("lbu_k2", result_w, 32'h000000FF);
        applyStimulus(0, 0, 1, 5'd4, 2'd1, 3'd3, 32'h3010, 32'h1002, 32'h80FF7F01, 32'd0);
        checkOutput("lh_k2", result_w, 32'hFFFF80FF);
        applyStimulus(0, 0, 1, 5'd5, 2'd1, 3'd4, 32'h3014, 32'h1000, 32'h80FF7F01, 32'd0);
        checkOutput("lhu_k0", result_w, 32'h00007F01);
        applyStimulus(0, 0, 1, 5'd6, 2'd1, 3'd7, 32'h3018, 32'h1003, 32'h80FF7F01, 32'd0);
        checkOutput("lw_odd_code", result_w, 32'h80FF7F01);

        // $0 suppression, then jal link value.
        applyStimulus(0, 0, 1, 5'd0, 2'd0, 3'd0, 32'h301C, 32'h55, 32'd0, 32'd0);
        checkOutput("zero_rfwr", {31'd0, rfwr_w}, 32'd0);
        applyStimulus(0, 0, 1, 5'd31, 2'd2, 3'd0, 32'h3004, 32'd0, 32'd0, 32'd0);
        checkOutput("jal_result", result_w, 32'h3008);
        checkOutput("jal_rd", {27'd0, rd_w}, 32'd31);

        // Stall, stall+flush, flush.
        held_pc4 = pc4_w;
        held_ret = ret_w;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 5'd7, 2'd3, 3'd0, 32'h4000 + 32'(i), 32'd1, 32'd2, 32'h77);
            checkOutput("stall_pc4", pc4_w, held_pc4);
            checkOutput("stall_ret", ret_w, held_ret);
        end
        applyStimulus(1, 1, 1, 5'd7, 2'd3, 3'd0, 32'h5000, 32'd1, 32'd2, 32'h77);
        checkOutput("stallflush_pc4", pc4_w, held_pc4);
        applyStimulus(0, 1, 1, 5'd7, 2'd3, 3'd0, 32'h6000, 32'd1, 32'd2, 32'h77);
        checkOutput("flush_rfwr", {31'd0, rfwr_w}, 32'd0);
        checkOutput("flush_pc4", pc4_w, 32'd0);
        checkOutput("flush_ret", ret_w, held_ret + 32'd1);
        idle();
        checkOutput("bubble_ret", ret_w, held_ret + 32'd1);

        // Counter wrap on the 4-bit instance: 17 retirements.
        asyncReset();
        for (int i = 0; i < 17; i++)
            applyStimulus(0, 0, 1, 5'd1, 2'd0, 3'd0, 32'h3000 + 32'(4 * i), 32'(i), 32'd0, 32'd0);
        idle();
        checkOutput("wrap_ret4", {28'd0, ret_w4}, 32'd1);
        checkOutput("wrap_ret32", ret_w, 32'd17);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                          1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                          ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                          $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
